// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns, digit indices and magnitude helper for seg_scan
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;

    localparam logic [2:0] DIG_SIGN_A = 3'd0;
    localparam logic [2:0] DIG_MAG_A  = 3'd1;
    localparam logic [2:0] DIG_SIGN_B = 3'd2;
    localparam logic [2:0] DIG_MAG_B  = 3'd3;
    localparam logic [2:0] DIG_SIGN_S = 3'd4;
    localparam logic [2:0] DIG_MAG_S  = 3'd5;

    // 4-bit two's-complement magnitude; -8 wraps to 4'b1000, read as unsigned 8
    function automatic logic [3:0] mag4(input logic [3:0] v);
        return v[3] ? (~v + 4'd1) : v;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 0..8 magnitude to active-low {g,f,e,d,c,b,a} pattern
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] mag,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (mag)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - six-digit multiplexed display of signed a, b, sum; optional SEG_SCAN_OV_BLINK_EN
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sum,
    input  logic       op,
    input  logic       ov,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       led_op,
    output logic       led_ov
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);

    logic [CW-1:0] pre;
    logic [2:0]    idx;
    logic          tick;
    logic          wrap;

    logic [3:0] snap_a;
    logic [3:0] snap_b;
    logic [3:0] snap_s;
    logic       snap_op;
    logic       snap_ov;

    assign tick = (pre == PRE_LAST);
    assign wrap = tick && (idx == DIG_MAG_S);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= DIG_SIGN_A;
            snap_a  <= '0;
            snap_b  <= '0;
            snap_s  <= '0;
            snap_op <= 1'b0;
            snap_ov <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + CW'(1);
            if (tick)
                idx <= wrap ? DIG_SIGN_A : idx + 3'd1;
            // capture only at the frame boundary so one frame never mixes old and new values
            if (wrap) begin
                snap_a  <= a;
                snap_b  <= b;
                snap_s  <= sum;
                snap_op <= op;
                snap_ov <= ov;
            end
        end
    end

    logic blank_sum;

`ifdef SEG_SCAN_OV_BLINK_EN
    logic [3:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (wrap)
            frame_cnt <= frame_cnt + 4'd1;
    end

    assign blank_sum = snap_ov && frame_cnt[3] && (idx[2:1] == 2'b10);
`else
    assign blank_sum = 1'b0;
`endif

    logic [3:0] sel_val;
    logic [3:0] sel_mag;
    logic [6:0] dec_pat;
    logic [6:0] seg_next;
    logic [5:0] an_next;

    always_comb begin
        sel_val = '0;
        case (idx[2:1])
            2'b00:   sel_val = snap_a;
            2'b01:   sel_val = snap_b;
            2'b10:   sel_val = snap_s;
            default: sel_val = '0;
        endcase
    end

    assign sel_mag = mag4(sel_val);

    seg7_decode u_decode (
        .mag     (sel_mag),
        .pattern (dec_pat)
    );

    // even indices are sign digits, odd indices magnitude digits
    always_comb begin
        seg_next = dec_pat;
        if (!idx[0])
            seg_next = sel_val[3] ? SEG_MINUS : SEG_BLANK;
        if (blank_sum)
            seg_next = SEG_BLANK;
    end

    assign an_next = ~(6'd1 << idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an     <= 6'b111111;
            seg    <= SEG_BLANK;
            led_op <= 1'b0;
            led_ov <= 1'b0;
        end else begin
            an     <= an_next;
            seg    <= seg_next;
            led_op <= snap_op;
            led_ov <= snap_ov;
        end
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 50000, meaning clock cycles per digit slot; legal range DIV >= 2.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  4  signed two's-complement operand A.
REQ-005 b  input  4  signed two's-complement operand B.
REQ-006 sum  input  4  signed two's-complement adder/subtractor result.
REQ-007 op  input  1  operation select, 0 add, 1 subtract.
REQ-008 ov  input  1  signed overflow flag.
REQ-009 an  output  6  digit enables, active-low, one-hot-low while scanning.
REQ-010 seg  output  7  shared segment bus, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 led_op  output  1  registered copy of the captured op.
REQ-012 led_ov  output  1  registered copy of the captured ov.

Function
REQ-013 Prescaler counts 0..DIV-1 and wraps to 0; tick is asserted in the cycle where the count equals DIV-1.
REQ-014 Digit index counts 0..5 and advances on each tick; on a tick at index 5 it wraps to 0.
REQ-015 Snapshot registers {a,b,sum,op,ov} load on the tick where the index wraps 5->0, so a frame is never torn; inputs are ignored at all other times.
REQ-016 Digit map: 0 sign A, 1 magnitude A, 2 sign B, 3 magnitude B, 4 sign sum, 5 magnitude sum; digit k drives an[k] low, all other an bits high.
REQ-017 Sign digit shows 7'b0111111 (minus) when the captured value is negative, otherwise 7'b1111111 (blank).
REQ-018 Magnitude is |value| computed in 4 bits; -8 (4'b1000) yields 8.
REQ-019 Magnitude patterns: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000; any other value gives blank.
REQ-020 an, seg, led_op and led_ov are registered and reflect the digit index and snapshot with exactly one clock of latency.
REQ-021 The tick counter and digit index keep running regardless of input changes; input changes never reset the scan.

Reset
REQ-022 While rst_n is low: prescaler 0, index 0, snapshot all 0, an 6'b111111, seg 7'b1111111, led_op 0, led_ov 0.
REQ-023 One cycle after rst_n rises, an is 6'b111110 and seg is blank (sign of snapshot zero); the first frame displays zeros.
REQ-024 Reset asserted mid-frame takes effect immediately and restarts the scan from digit 0.

Configuration
REQ-025 With SEG_SCAN_OV_BLINK_EN defined, a 4-bit frame counter increments on every 5->0 wrap; when captured ov=1 and frame counter bit 3 is 1, seg is blank for digits 4 and 5 while an still selects them.
REQ-026 Without SEG_SCAN_OV_BLINK_EN, the frame counter is absent and the sum digits are always displayed.

Structure
REQ-027 Shared package seg_pkg holds SEG_BLANK, SEG_MINUS, the nine digit pattern constants and the digit-index constants.
REQ-028 Sub-module seg7_decode (4-bit magnitude in, 7-bit active-low pattern out, combinational) is instantiated once on the muxed magnitude.

Verification (DIV=4)
REQ-029 Hold rst_n low -> an=111111, seg=1111111, leds 0; release -> next cycle an=111110, seg=1111111.
REQ-030 Free run -> an changes every 4 cycles, sequence 111110,111101,111011,110111,101111,011111, frame length 24 cycles, wraps to 111110.
REQ-031 a=1101, b=0010, sum=1111, op=0 after a capture -> seg per digit: 0111111, 0110000, 1111111, 0100100, 0111111, 1111001; led_op=0.
REQ-032 Change a from 0011 to 0101 mid-frame -> magnitude-A digit shows 0110000 until the next 5->0 wrap, then 0010010.
REQ-033 a=1000 -> sign A 0111111, magnitude A 0000000.
REQ-034 ov=1 held, macro defined -> digits 4 and 5 shown for 8 frames, blank for 8 frames, led_ov=1; macro undefined -> always shown.
